// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder_loader_pkg
// Purpose : Shared types and constants for the RV32I instruction encoder/loader:
//           instruction format enum, loader FSM states, base opcodes, canonical
//           NOP, and a signed range helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic imm_in_range(input logic signed [31:0] v,
                                        input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder_loader_if
// Purpose : Field-bundle handshake plus sequential memory write port of the
//           instruction loader.
// Ports   : valid_i/ready_o handshake, fmt/opcode/funct/reg/imm/last fields,
//           mem_we_o/mem_addr_o/mem_wdata_o/mem_gnt_i write port.
//           slave = loader view, master = producer/memory environment view.
// Revision: 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  valid_i;
  logic                  ready_o;
  logic [2:0]            fmt_i;
  logic [6:0]            opcode_i;
  logic [2:0]            funct3_i;
  logic [6:0]            funct7_i;
  logic [4:0]            rd_i;
  logic [4:0]            rs1_i;
  logic [4:0]            rs2_i;
  logic [31:0]           imm_i;
  logic                  last_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_gnt_i;

  modport slave (
    input  valid_i, fmt_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i,
           imm_i, last_i, mem_gnt_i,
    output ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output valid_i, fmt_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i,
           imm_i, last_i, mem_gnt_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/instr_encode_comb.sv
`default_nettype none
// ============================================================================
// Module  : instr_encode_comb
// Purpose : Purely combinational RV32I field packer. Produces the encoded word
//           and an error flag for out-of-range immediates or illegal formats;
//           on error the word is forced to the canonical NOP.
// Ports   : i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm in;
//           o_word (32b), o_err out.
// Revision: 1.0 - initial release
// ============================================================================
module instr_encode_comb
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic signed [31:0] w_imm;
  logic [31:0]        w_raw;
  logic               w_bad;

  assign w_imm = $signed(i_imm);

  always_comb begin
    w_raw = '0;
    w_bad = 1'b0;
    case (i_fmt)
      FMT_R: begin
        w_raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_I: begin
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_bad = !imm_in_range(w_imm, -2048, 2047);
      end
      FMT_S: begin
        w_raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_bad = !imm_in_range(w_imm, -2048, 2047);
      end
      FMT_B: begin
        w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                 i_imm[4:1], i_imm[11], i_opcode};
        w_bad = !imm_in_range(w_imm, -4096, 4094) || i_imm[0];
      end
      FMT_U: begin
        w_raw = {i_imm[31:12], i_rd, i_opcode};
        w_bad = (i_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        w_raw = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        w_bad = !imm_in_range(w_imm, -1048576, 1048574) || i_imm[0];
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  assign o_word = w_bad ? NOP_INSTR : w_raw;
  assign o_err  = w_bad;

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder_loader
// Purpose : Accepts instruction field bundles, encodes them into RV32I words
//           and streams them through a single output register into a
//           sequential instruction-memory write port starting at BASE_ADDR.
// Ports   : clk, rstn_i (sync active-low), start_i pulse;
//           bus (slave modport): field handshake + memory write port;
//           count_o words granted since start, done_o level, error_o sticky.
// Revision: 1.0 - initial release
// ============================================================================
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  start_i,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(BASE_ADDR);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_err;

  logic [31:0]           w_enc_word;
  logic                  w_enc_err;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_gnt;
  logic                  w_at_top;
  logic                  w_start;

  instr_encode_comb u_enc (
    .i_fmt    (bus.fmt_i),
    .i_opcode (bus.opcode_i),
    .i_funct3 (bus.funct3_i),
    .i_funct7 (bus.funct7_i),
    .i_rd     (bus.rd_i),
    .i_rs1    (bus.rs1_i),
    .i_rs2    (bus.rs2_i),
    .i_imm    (bus.imm_i),
    .o_word   (w_enc_word),
    .o_err    (w_enc_err)
  );

  assign w_gnt    = r_we && bus.mem_gnt_i;
  assign w_at_top = (r_addr == '1);
  // While the register holds the word for the top address, no further bundle
  // may be taken: it would have no address to go to.
  assign w_ready  = (r_state == ST_LOAD) && (!r_we || bus.mem_gnt_i) &&
                    !(r_we && w_at_top);
  assign w_accept = bus.valid_i && w_ready;
  assign w_start  = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (w_accept && bus.last_i)  w_state_nxt = ST_DRAIN;
        else if (w_gnt && w_at_top)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (!r_we || w_gnt) w_state_nxt = ST_DONE;
      ST_DONE:  if (start_i) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= C_BASE;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        // Output register is always empty in IDLE/DONE, so no grant can race this.
        r_addr  <= C_BASE;
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_gnt) begin
          r_count <= r_count + 1'b1;
          if (!w_at_top) r_addr <= r_addr + 1'b1;
          // Top-of-window grant while still in LOAD means last_i never arrived.
          if (w_at_top && (r_state == ST_LOAD)) r_err <= 1'b1;
        end
        if (w_accept) begin
          r_we    <= 1'b1;
          r_wdata <= w_enc_word;
          if (w_enc_err) r_err <= 1'b1;
        end else if (w_gnt) begin
          r_we <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign count_o         = r_count;
  assign done_o          = (r_state == ST_DONE);
  assign error_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_encoder_loader
// Purpose : Self-checking bench for instr_encoder_loader with a 4-word window.
//           Directed bundles push hand-computed {addr, word} pairs into a
//           scoreboard queue; a monitor pops and compares on every grant.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int AW = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rstn_i;
  logic          start_i;
  logic [AW:0]   count_o;
  logic          done_o;
  logic          error_o;

  instr_encoder_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk     (clk),
    .rstn_i  (rstn_i),
    .start_i (start_i),
    .bus     (bus),
    .count_o (count_o),
    .done_o  (done_o),
    .error_o (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [AW+31:0] sb_q[$];
  logic [AW-1:0]  exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic           m_prev_stall = 1'b0;
  logic [AW-1:0]  m_h_addr;
  logic [31:0]    m_h_data;
  logic           m_cnt_pend = 1'b0;
  logic [AW:0]    m_cnt_exp;
  logic [AW+31:0] m_ent;

  always @(negedge clk) begin
    if (m_cnt_pend) begin
      chk("count_after_grant", 32'(count_o), 32'(m_cnt_exp));
      m_cnt_pend = 1'b0;
    end
    if (rstn_i && bus.mem_we_o && bus.mem_gnt_i) begin
      m_prev_stall = 1'b0;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        m_ent = sb_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr_o), 32'(m_ent[AW+31:32]));
        chk("wr_data", bus.mem_wdata_o, m_ent[31:0]);
        m_cnt_exp  = {1'b0, m_ent[AW+31:32]} + 1'b1;
        m_cnt_pend = 1'b1;
      end
    end else if (rstn_i && bus.mem_we_o && !bus.mem_gnt_i) begin
      chk("stall_ready_low", 32'(bus.ready_o), 32'd0);
      if (m_prev_stall) begin
        chk("stall_addr_stable", 32'(bus.mem_addr_o), 32'(m_h_addr));
        chk("stall_data_stable", bus.mem_wdata_o, m_h_data);
      end
      m_h_addr     = bus.mem_addr_o;
      m_h_data     = bus.mem_wdata_o;
      m_prev_stall = 1'b1;
    end else begin
      m_prev_stall = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp, input int bound,
                      output logic acc, output int acc_cyc);
    int n;
    bus.fmt_i = fmt; bus.opcode_i = op; bus.funct3_i = f3; bus.funct7_i = f7;
    bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2; bus.imm_i = imm;
    bus.last_i = last; bus.valid_i = 1'b1;
    acc = 1'b0; acc_cyc = 0; n = 0;
    while (!acc && n < bound) begin
      @(negedge clk);
      if (bus.ready_o) acc = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    if (acc) begin
      sb_q.push_back({exp_addr, exp});
      exp_addr = exp_addr + 1'b1;
      acc_cyc  = cyc;
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    @(negedge clk);
    while (!done_o && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(done_o), 32'd1);
    @(posedge clk); #1;
  endtask

  logic acc;
  int   c1, c2, c3, c4;

  initial begin
    rstn_i = 1'b0; start_i = 1'b0;
    bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.mem_gnt_i = 1'b1;
    bus.fmt_i = '0; bus.opcode_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
    bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.imm_i = '0;
    exp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("rst_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    rstn_i = 1'b1;
    @(posedge clk); #1;

    // Sequence 1: I, R, S, B(last)
    do_start();
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 10, acc, c1);
    chk("acc_I", 32'(acc), 32'd1);
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3, 10, acc, c1);
    chk("acc_R", 32'(acc), 32'd1);
    send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_A423, 10, acc, c1);
    chk("acc_S", 32'(acc), 32'd1);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b1, 32'hFE20_8EE3, 10, acc, c1);
    chk("acc_B", 32'(acc), 32'd1);
    wait_done(20);
    chk("s1_err", 32'(error_o), 32'd0);
    chk("s1_count", 32'(count_o), 32'd4);
    chk("s1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Sequence 2: J, U(last)
    do_start();
    @(negedge clk);
    chk("s2_start_count", 32'(count_o), 32'd0);
    chk("s2_start_done", 32'(done_o), 32'd0);
    @(posedge clk); #1;
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0010_00EF, 10, acc, c1);
    send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7, 10, acc, c1);
    wait_done(20);
    chk("s2_count", 32'(count_o), 32'd2);
    chk("s2_err", 32'(error_o), 32'd0);

    // Sequence 3: range errors become NOPs, error sticky
    do_start();
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, NOP, 10, acc, c1);
    @(negedge clk);
    chk("s3_err_after_B", 32'(error_o), 32'd1);
    @(posedge clk); #1;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, NOP, 10, acc, c1);
    wait_done(20);
    chk("s3_err_sticky", 32'(error_o), 32'd1);
    chk("s3_count", 32'(count_o), 32'd2);

    // Sequence 4: grant stall, then back-to-back resumes
    do_start();
    bus.mem_gnt_i = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.mem_gnt_i = 1'b1;
      end
    join_none
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0113, 10, acc, c1);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd4, 5'd2, 5'd3, 32'd0, 1'b0, 32'h4031_0233, 10, acc, c2);
    chk("s4_acc_after_stall", 32'(acc), 32'd1);
    send(3'd2, 7'h23, 3'd0, 7'h00, 5'd0, 5'd2, 5'd5, -32'sd8, 1'b0, 32'hFE51_0C23, 10, acc, c3);
    send(3'd4, 7'h17, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hFFFF_F000, 1'b1, 32'hFFFF_F397, 10, acc, c4);
    chk("s4_b2b_1", 32'(c3 - c2), 32'd1);
    chk("s4_b2b_2", 32'(c4 - c3), 32'd1);
    wait_done(20);
    chk("s4_count", 32'(count_o), 32'd4);
    chk("s4_err", 32'(error_o), 32'd0);

    // Sequence 5: window full without last_i
    do_start();
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093, 10, acc, c1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h0020_0113, 10, acc, c1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 32'h0030_0193, 10, acc, c1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4, 1'b0, 32'h0040_0213, 10, acc, c1);
    chk("s5_acc_4th", 32'(acc), 32'd1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0293, 8, acc, c1);
    chk("s5_5th_refused", 32'(acc), 32'd0);
    wait_done(20);
    chk("s5_err", 32'(error_o), 32'd1);
    chk("s5_count", 32'(count_o), 32'd4);
    chk("s5_sb_empty", 32'(sb_q.size()), 32'd0);
    do_start();
    @(negedge clk);
    chk("s5_restart_count", 32'(count_o), 32'd0);
    chk("s5_restart_err", 32'(error_o), 32'd0);
    chk("s5_restart_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("s5_restart_ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;

    // Sequence 6: reset mid-stream discards the pending write
    bus.mem_gnt_i = 1'b0;
    send(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, NOP, 10, acc, c1);
    @(negedge clk);
    chk("s6_err_illegal_fmt", 32'(error_o), 32'd1);
    chk("s6_wdata_nop", bus.mem_wdata_o, NOP);
    @(posedge clk); #1;
    rstn_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("s6_rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("s6_rst_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("s6_rst_wdata", bus.mem_wdata_o, 32'd0);
    chk("s6_rst_count", 32'(count_o), 32'd0);
    chk("s6_rst_done", 32'(done_o), 32'd0);
    chk("s6_rst_err", 32'(error_o), 32'd0);
    chk("s6_rst_ready", 32'(bus.ready_o), 32'd0);
    rstn_i = 1'b1;
    sb_q.delete();
    bus.mem_gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s6_idle_no_write", 32'(bus.mem_we_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
